prg_dma_arb: RTL and testbench

Schedules memory-side accesses from two non-CPU requesters (A: PI DMA, B: save-state engine) onto the shared PRG/SRM SRAM bus. Each access fits inside an M2-low window, when the cartridge CPU path is idle. The block owns the bus only for a fixed, short burst after each M2 falling edge. It drives the `req_prg`/`req_srm` override that selects it over mapper control, generates CE/OE/WE strobes, and arbitrates round-robin between A and B.

---
 rtl/prg_dma_arb_if.sv | 47 ++++
 rtl/prg_dma_arb.sv | 176 +++++++++++++++++
 tb/tb_prg_dma_arb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_dma_arb_if.sv
// prg_dma_arb_if
// Bundles the requester handshakes (A = PI DMA, B = save-state engine),
// the shared read-data return and the PRG/SRM SRAM bus driven by the arbiter.
//   slave  : the arbiter side (takes requests + mem_do, drives bus/acks)
//   master : the requester/memory side (drives requests + mem_do)
interface prg_dma_arb_if;
  logic        a_req;
  logic        a_we;
  logic        a_srm;
  logic [21:0] a_addr;
  logic [7:0]  a_din;
  logic        a_ack;

  logic        b_req;
  logic        b_we;
  logic        b_srm;
  logic [21:0] b_addr;
  logic [7:0]  b_din;
  logic        b_ack;

  logic [7:0]  rd_dat;
  logic [7:0]  mem_do;
  logic        req_prg;
  logic        req_srm;
  logic [21:0] mem_addr;
  logic [7:0]  mem_dati;
  logic        mem_ce;
  logic        mem_oe;
  logic        mem_we;
  logic        busy;

  modport slave (
    input  a_req, a_we, a_srm, a_addr, a_din,
    input  b_req, b_we, b_srm, b_addr, b_din,
    input  mem_do,
    output a_ack, b_ack, rd_dat,
    output req_prg, req_srm, mem_addr, mem_dati, mem_ce, mem_oe, mem_we, busy
  );

  modport master (
    output a_req, a_we, a_srm, a_addr, a_din,
    output b_req, b_we, b_srm, b_addr, b_din,
    output mem_do,
    input  a_ack, b_ack, rd_dat,
    input  req_prg, req_srm, mem_addr, mem_dati, mem_ce, mem_oe, mem_we, busy
  );
endinterface

// File: rtl/prg_dma_arb.sv
// prg_dma_arb
// Squeezes single-byte accesses from two non-CPU requesters into the M2-low
// window of the cartridge bus. One access per window, started only by the
// synchronised M2 falling edge; round-robin between A and B on ties.
// Ports:
//   i_clk   system clock (rising edge)
//   i_rst   asynchronous active-high reset
//   i_m2    raw CPU M2 pin, asynchronous to i_clk
//   io_bus  requester handshakes, read data and SRAM bus (slave modport)
// Parameter STROBE_CLKS: OE/WE pulse width in clocks, legal 1..8.
//
// state  | meaning
// IDLE   | bus released, waiting for an M2 fall with a pending request
// SETUP  | CE, override and address/data driven, strobes still low
// STROBE | OE (read) or WE (write) asserted for STROBE_CLKS cycles
// HOLD   | strobes low, CE/address/data held one more cycle before release
module prg_dma_arb #(
  parameter int STROBE_CLKS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m2,
  prg_dma_arb_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(STROBE_CLKS - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_m2_s1;
  logic        r_m2_s2;
  logic        r_m2_d;
  logic        r_last;    // 1 = B completed last, 0 = A
  logic        r_gnt_b;
  logic        r_we;
  logic        r_req_prg;
  logic        r_req_srm;
  logic        r_mem_ce;
  logic        r_mem_oe;
  logic        r_mem_we;
  logic [21:0] r_mem_addr;
  logic [7:0]  r_mem_dati;
  logic [7:0]  r_rd_dat;
  logic        r_a_ack;
  logic        r_b_ack;
  logic        r_busy;

  logic        w_fall;
  logic        w_gnt_b;
  logic        w_sel_we;
  logic        w_sel_srm;
  logic [21:0] w_sel_addr;
  logic [7:0]  w_sel_din;

  assign w_fall = r_m2_d & ~r_m2_s2;

  // B wins only when A is absent or A was the last one served.
  assign w_gnt_b    = io_bus.b_req & (~io_bus.a_req | ~r_last);
  assign w_sel_we   = w_gnt_b ? io_bus.b_we   : io_bus.a_we;
  assign w_sel_srm  = w_gnt_b ? io_bus.b_srm  : io_bus.a_srm;
  assign w_sel_addr = w_gnt_b ? io_bus.b_addr : io_bus.a_addr;
  assign w_sel_din  = w_gnt_b ? io_bus.b_din  : io_bus.a_din;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Synchroniser resets high so releasing reset never looks like a fall.
      r_m2_s1    <= 1'b1;
      r_m2_s2    <= 1'b1;
      r_m2_d     <= 1'b1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_gnt_b    <= 1'b0;
      r_we       <= 1'b0;
      r_req_prg  <= 1'b0;
      r_req_srm  <= 1'b0;
      r_mem_ce   <= 1'b0;
      r_mem_oe   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_dati <= '0;
      r_rd_dat   <= '0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_m2_s1 <= i_m2;
      r_m2_s2 <= r_m2_s1;
      r_m2_d  <= r_m2_s2;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;

      if (r_state == ST_IDLE) begin
        if (w_fall && (io_bus.a_req || io_bus.b_req)) begin
          r_gnt_b    <= w_gnt_b;
          r_we       <= w_sel_we;
          r_req_prg  <= ~w_sel_srm;
          r_req_srm  <= w_sel_srm;
          r_mem_ce   <= 1'b1;
          r_mem_addr <= w_sel_addr;
          r_mem_dati <= w_sel_din;
          r_busy     <= 1'b1;
          r_state    <= ST_SETUP;
        end
      end else if (r_m2_s2) begin
        // M2 came back high while we still own the bus: drop everything,
        // no ack, arbitration history untouched so the same requester retries.
        r_req_prg  <= 1'b0;
        r_req_srm  <= 1'b0;
        r_mem_ce   <= 1'b0;
        r_mem_oe   <= 1'b0;
        r_mem_we   <= 1'b0;
        r_mem_addr <= '0;
        r_mem_dati <= '0;
        r_busy     <= 1'b0;
        r_state    <= ST_IDLE;
      end else begin
        case (r_state)
          ST_SETUP: begin
            r_mem_oe <= ~r_we;
            r_mem_we <= r_we;
            r_cnt    <= CNT_LOAD;
            r_state  <= ST_STROBE;
          end
          ST_STROBE: begin
            if (r_cnt == 3'd0) begin
              r_mem_oe <= 1'b0;
              r_mem_we <= 1'b0;
              if (!r_we) begin
                r_rd_dat <= io_bus.mem_do;
              end
              r_state <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          ST_HOLD: begin
            r_req_prg  <= 1'b0;
            r_req_srm  <= 1'b0;
            r_mem_ce   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dati <= '0;
            r_a_ack    <= ~r_gnt_b;
            r_b_ack    <= r_gnt_b;
            r_last     <= r_gnt_b;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.req_prg  = r_req_prg;
  assign io_bus.req_srm  = r_req_srm;
  assign io_bus.mem_ce   = r_mem_ce;
  assign io_bus.mem_oe   = r_mem_oe;
  assign io_bus.mem_we   = r_mem_we;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.mem_dati = r_mem_dati;
  assign io_bus.rd_dat   = r_rd_dat;
  assign io_bus.a_ack    = r_a_ack;
  assign io_bus.b_ack    = r_b_ack;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_prg_dma_arb.sv
// tb_prg_dma_arb
// Drives M2 windows and requests; expected acks (who, read data) are queued
// when a request is set up and popped by a monitor when an ack appears.
// Per-window strobe/override cycle counts are checked inline by each test.
module tb_prg_dma_arb;

  logic clk = 1'b0;
  logic rst;
  logic m2;

  always #5 clk = ~clk;

  prg_dma_arb_if bus ();

  prg_dma_arb #(.STROBE_CLKS(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_m2   (m2),
    .io_bus (bus.slave)
  );

  typedef struct {
    bit         is_b;
    bit         chk_rd;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          ce_n, oe_n, we_n, prg_n, srm_n, busy_n, acka_n, ackb_n;
  int          ce_first, ack_at;
  logic [21:0] addr_seen;
  logic [7:0]  dati_seen;
  bit          addr_unstable;

  // scoreboard monitor: every ack must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (bus.a_ack === 1'b1 || bus.b_ack === 1'b1)) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_ack a_ack=%0b b_ack=%0b want=none", bus.a_ack, bus.b_ack);
        end else begin
          e = sb.pop_front();
          if (bus.b_ack !== e.is_b || bus.a_ack !== !e.is_b) begin
            n_errors++;
            $display("FAIL sb_ack_owner a_ack=%0b b_ack=%0b want_b=%0b", bus.a_ack, bus.b_ack, e.is_b);
          end
          if (e.chk_rd) begin
            n_checks++;
            if (bus.rd_dat !== e.rd) begin
              n_errors++;
              $display("FAIL sb_rd_dat got=%h want=%h", bus.rd_dat, e.rd);
            end
          end
        end
      end
    end
  end

  // One M2-low window: m2 sampled low for 'low' rising edges, observed for 'total'.
  task automatic run_window(input int low, input int total);
    ce_n = 0; oe_n = 0; we_n = 0; prg_n = 0; srm_n = 0; busy_n = 0;
    acka_n = 0; ackb_n = 0; ce_first = -1; ack_at = -1;
    addr_seen = '0; dati_seen = '0; addr_unstable = 1'b0;
    @(negedge clk);
    m2 = 1'b0;
    for (int i = 0; i < total; i++) begin
      @(posedge clk);
      #1;
      if (i + 1 == low) m2 = 1'b1;
      if (bus.mem_ce === 1'b1) begin
        if (ce_first < 0) begin
          ce_first  = i;
          addr_seen = bus.mem_addr;
        end else if (bus.mem_addr !== addr_seen) begin
          addr_unstable = 1'b1;
        end
        dati_seen = bus.mem_dati;
        ce_n++;
      end
      if (bus.mem_oe === 1'b1)  oe_n++;
      if (bus.mem_we === 1'b1)  we_n++;
      if (bus.req_prg === 1'b1) prg_n++;
      if (bus.req_srm === 1'b1) srm_n++;
      if (bus.busy === 1'b1)    busy_n++;
      if (bus.a_ack === 1'b1) begin acka_n++; ack_at = i; end
      if (bus.b_ack === 1'b1) begin ackb_n++; ack_at = i; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m2 = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_srm = 0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_srm = 0; bus.b_addr = '0; bus.b_din = '0;
    bus.mem_do = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.req_prg, bus.req_srm, bus.mem_ce, bus.mem_oe, bus.mem_we, bus.busy, bus.a_ack, bus.b_ack} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_ctrl got=%b want=00000000",
               {bus.req_prg, bus.req_srm, bus.mem_ce, bus.mem_oe, bus.mem_we, bus.busy, bus.a_ack, bus.b_ack});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_dati, bus.rd_dat} !== 38'h0) begin
      n_errors++;
      $display("FAIL reset_data addr=%h dati=%h rd=%h want=0", bus.mem_addr, bus.mem_dati, bus.rd_dat);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_no_window();
    int ce_c = 0;
    int busy_c = 0;
    bus.a_req = 1; bus.a_addr = 22'h000100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ce === 1'b1) ce_c++;
      if (bus.busy === 1'b1)   busy_c++;
    end
    n_checks++;
    if (ce_c != 0 || busy_c != 0) begin
      n_errors++;
      $display("FAIL no_window_activity ce_cycles=%0d busy_cycles=%0d want=0", ce_c, busy_c);
    end
    bus.a_req = 0;
  endtask

  task automatic test_single_read();
    bus.a_req = 1; bus.a_we = 0; bus.a_srm = 0; bus.a_addr = 22'h012345;
    bus.mem_do = 8'h5A;
    sb.push_back('{is_b: 1'b0, chk_rd: 1'b1, rd: 8'h5A});
    run_window(10, 14);
    bus.a_req = 0;
    n_checks++;
    if (ce_n != 6 || prg_n != 6) begin
      n_errors++; $display("FAIL read_ce_prg ce=%0d prg=%0d want=6", ce_n, prg_n);
    end
    n_checks++;
    if (oe_n != 4 || we_n != 0 || srm_n != 0) begin
      n_errors++; $display("FAIL read_strobes oe=%0d we=%0d srm=%0d want=4,0,0", oe_n, we_n, srm_n);
    end
    n_checks++;
    if (ce_first != 2 || ack_at != 8 || acka_n != 1 || ackb_n != 0) begin
      n_errors++;
      $display("FAIL read_timing ce_first=%0d ack_at=%0d acka=%0d ackb=%0d want=2,8,1,0", ce_first, ack_at, acka_n, ackb_n);
    end
    n_checks++;
    if (addr_seen !== 22'h012345 || addr_unstable) begin
      n_errors++; $display("FAIL read_addr got=%h unstable=%0b want=012345", addr_seen, addr_unstable);
    end
  endtask

  task automatic test_srm_write();
    bus.b_req = 1; bus.b_we = 1; bus.b_srm = 1; bus.b_addr = 22'h000777; bus.b_din = 8'hC3;
    bus.mem_do = 8'h99;
    sb.push_back('{is_b: 1'b1, chk_rd: 1'b0, rd: 8'h00});
    run_window(10, 14);
    bus.b_req = 0;
    n_checks++;
    if (srm_n != 6 || prg_n != 0) begin
      n_errors++; $display("FAIL write_override srm=%0d prg=%0d want=6,0", srm_n, prg_n);
    end
    n_checks++;
    if (we_n != 4 || oe_n != 0) begin
      n_errors++; $display("FAIL write_strobes we=%0d oe=%0d want=4,0", we_n, oe_n);
    end
    n_checks++;
    if (dati_seen !== 8'hC3 || addr_seen !== 22'h000777) begin
      n_errors++; $display("FAIL write_data dati=%h addr=%h want=c3,000777", dati_seen, addr_seen);
    end
    n_checks++;
    if (ackb_n != 1 || acka_n != 0 || bus.rd_dat !== 8'h5A) begin
      n_errors++; $display("FAIL write_ack ackb=%0d acka=%0d rd=%h want=1,0,5a", ackb_n, acka_n, bus.rd_dat);
    end
  endtask

  task automatic test_contention();
    bus.a_req = 1; bus.a_we = 0; bus.a_srm = 0; bus.a_addr = 22'h00AAAA;
    bus.b_req = 1; bus.b_we = 0; bus.b_srm = 1; bus.b_addr = 22'h00BBBB;
    for (int w = 0; w < 4; w++) begin
      bus.mem_do = 8'h10 + 8'(w);
      sb.push_back('{is_b: w[0], chk_rd: 1'b1, rd: 8'h10 + 8'(w)});
      run_window(10, 14);
      n_checks++;
      if (acka_n + ackb_n != 1 || (w[0] ? ackb_n : acka_n) != 1) begin
        n_errors++;
        $display("FAIL contention_grant window=%0d acka=%0d ackb=%0d want_b=%0b", w, acka_n, ackb_n, w[0]);
      end
      n_checks++;
      if (srm_n != (w[0] ? 6 : 0) || prg_n != (w[0] ? 0 : 6)) begin
        n_errors++;
        $display("FAIL contention_target window=%0d srm=%0d prg=%0d", w, srm_n, prg_n);
      end
    end
    bus.a_req = 0; bus.b_req = 0;
  endtask

  task automatic test_abort();
    bus.a_req = 1; bus.a_we = 0; bus.a_srm = 0; bus.a_addr = 22'h3FFFFF;
    bus.mem_do = 8'hEE;
    run_window(3, 8);
    n_checks++;
    if (acka_n != 0 || ackb_n != 0 || ce_n != 3 || oe_n != 2 || busy_n != 3) begin
      n_errors++;
      $display("FAIL abort_cut acka=%0d ackb=%0d ce=%0d oe=%0d busy=%0d want=0,0,3,2,3", acka_n, ackb_n, ce_n, oe_n, busy_n);
    end
    n_checks++;
    if (bus.rd_dat !== 8'h13) begin
      n_errors++; $display("FAIL abort_rd_kept got=%h want=13", bus.rd_dat);
    end
    sb.push_back('{is_b: 1'b0, chk_rd: 1'b1, rd: 8'hEE});
    run_window(10, 14);
    bus.a_req = 0;
    n_checks++;
    if (acka_n != 1 || oe_n != 4 || addr_seen !== 22'h3FFFFF) begin
      n_errors++; $display("FAIL abort_retry acka=%0d oe=%0d addr=%h want=1,4,3fffff", acka_n, oe_n, addr_seen);
    end
  endtask

  task automatic test_reset_midop();
    int ce_c = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_srm = 0; bus.a_addr = 22'h055555;
    bus.mem_do = 8'h77;
    @(negedge clk);
    m2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_oe !== 1'b1) begin
      n_errors++; $display("FAIL midop_in_strobe oe=%b want=1", bus.mem_oe);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_prg, bus.req_srm, bus.mem_ce, bus.mem_oe, bus.mem_we, bus.busy, bus.a_ack, bus.b_ack} !== 8'h00 ||
        {bus.mem_addr, bus.mem_dati, bus.rd_dat} !== 38'h0) begin
      n_errors++;
      $display("FAIL midop_reset_outputs ctrl=%b addr=%h dati=%h rd=%h want=0",
               {bus.req_prg, bus.req_srm, bus.mem_ce, bus.mem_oe, bus.mem_we, bus.busy, bus.a_ack, bus.b_ack},
               bus.mem_addr, bus.mem_dati, bus.rd_dat);
    end
    m2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ce === 1'b1 || bus.busy === 1'b1) ce_c++;
    end
    n_checks++;
    if (ce_c != 0) begin
      n_errors++; $display("FAIL midop_no_restart active_cycles=%0d want=0", ce_c);
    end
    sb.push_back('{is_b: 1'b0, chk_rd: 1'b1, rd: 8'h77});
    run_window(10, 14);
    bus.a_req = 0;
    n_checks++;
    if (acka_n != 1 || ackb_n != 0) begin
      n_errors++; $display("FAIL midop_fresh_window acka=%0d ackb=%0d want=1,0", acka_n, ackb_n);
    end
  endtask

  initial begin
    test_reset();
    test_no_window();
    test_single_read();
    test_srm_write();
    test_contention();
    test_abort();
    test_reset_midop();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL sb_leftover pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
